// File: rtl/latch_write_sequencer_pkg.sv
// Shared types and helpers for the latch write sequencer: FSM state encoding,
// the address-to-enable decoder and a small constant helper for counter sizing.
package latch_seq_pkg;

    // Sequencer phases: wait for a request, settle d, open the latch, settle again.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ENABLE = 2'd2,
        HOLD   = 2'd3
    } seq_state_t;

    // Widest latch bank the decoder supports; callers cast the result down.
    localparam int unsigned MAX_LATCH = 32;

    // One-hot enable pattern for addr, or all zeros when addr is outside the bank.
    function automatic logic [MAX_LATCH-1:0] onehot_dec(
        input logic [31:0] addr,
        input int unsigned num_latch
    );
        logic [MAX_LATCH-1:0] vec;
        if (addr < num_latch) begin
            vec = {{(MAX_LATCH-1){1'b0}}, 1'b1} << addr;
        end else begin
            vec = {MAX_LATCH{1'b0}};
        end
        return vec;
    endfunction

    // Largest of three phase lengths, used to size the shared down-counter.
    function automatic int unsigned max3(
        input int unsigned a,
        input int unsigned b,
        input int unsigned c
    );
        int unsigned m;
        m = a;
        if (b > m) begin
            m = b;
        end else begin
            m = m;
        end
        if (c > m) begin
            m = c;
        end else begin
            m = m;
        end
        return m;
    endfunction

endpackage

// File: rtl/latch_write_sequencer.sv
// Drives a bank of transparent latches: each accepted write presents d for a
// setup window, pulses one enable bit, then keeps d stable for a hold window,
// so a latch never sees its data change while it is open.
module latch_write_sequencer
    import latch_seq_pkg::*;
#(
    parameter int WIDTH        = 8,
    parameter int NUM_LATCH    = 4,
    parameter int ADDR_W       = 2,
    parameter int SETUP_CYCLES = 1,
    parameter int ENA_CYCLES   = 2,
    parameter int HOLD_CYCLES  = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [ADDR_W-1:0]    req_addr,
    input  logic [WIDTH-1:0]     req_data,
    output logic [WIDTH-1:0]     d,
    output logic [NUM_LATCH-1:0] ena,
    output logic                 busy,
    output logic                 done,
    output logic                 err
);

    // One counter serves all three timed phases, so size it for the longest.
    localparam int unsigned MAX_CYCLES = max3(SETUP_CYCLES, ENA_CYCLES, HOLD_CYCLES);
    localparam int          CNT_W      = $clog2(MAX_CYCLES + 1);

    localparam logic [CNT_W-1:0] SETUP_LOAD = CNT_W'(SETUP_CYCLES - 1);
    localparam logic [CNT_W-1:0] ENA_LOAD   = CNT_W'(ENA_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LOAD  = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1'b1);
    localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};

    seq_state_t           state_r;
    logic [CNT_W-1:0]     cnt_r;
    logic [NUM_LATCH-1:0] sel_r;      // enable pattern of the write in flight
    logic                 oor_r;      // write in flight targets no latch
    logic [WIDTH-1:0]     d_r;
    logic [NUM_LATCH-1:0] ena_r;
    logic                 busy_r;
    logic                 done_r;
    logic                 err_r;

    logic                 ready_s;
    logic                 accept_s;
    logic                 cnt_zero_s;
    logic [NUM_LATCH-1:0] req_sel_s;
    logic                 req_oor_s;

    // Handshake and request decode; ready depends only on state and reset.
    always_comb begin
        ready_s    = (state_r == IDLE) && !reset;
        accept_s   = req_valid && ready_s;
        cnt_zero_s = (cnt_r == CNT_ZERO);
        req_sel_s  = NUM_LATCH'(onehot_dec(32'(req_addr), NUM_LATCH));
        req_oor_s  = (32'(req_addr) >= 32'(NUM_LATCH));
    end

    // Sequencer FSM with its phase counter and all registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
            cnt_r   <= CNT_ZERO;
            sel_r   <= {NUM_LATCH{1'b0}};
            oor_r   <= 1'b0;
            d_r     <= {WIDTH{1'b0}};
            ena_r   <= {NUM_LATCH{1'b0}};
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            err_r   <= 1'b0;
        end else begin
            // Completion flags are single-cycle pulses unless re-raised below.
            done_r <= 1'b0;
            err_r  <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        d_r     <= req_data;
                        sel_r   <= req_sel_s;
                        oor_r   <= req_oor_s;
                        cnt_r   <= SETUP_LOAD;
                        busy_r  <= 1'b1;
                        state_r <= SETUP;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                SETUP: begin
                    if (cnt_zero_s) begin
                        // sel_r is all zeros for an out-of-range write.
                        ena_r   <= sel_r;
                        cnt_r   <= ENA_LOAD;
                        state_r <= ENABLE;
                    end else begin
                        cnt_r <= cnt_r - CNT_ONE;
                    end
                end
                ENABLE: begin
                    if (cnt_zero_s) begin
                        ena_r   <= {NUM_LATCH{1'b0}};
                        cnt_r   <= HOLD_LOAD;
                        state_r <= HOLD;
                    end else begin
                        cnt_r <= cnt_r - CNT_ONE;
                    end
                end
                HOLD: begin
                    if (cnt_zero_s) begin
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                        err_r   <= oor_r;
                        state_r <= IDLE;
                    end else begin
                        cnt_r <= cnt_r - CNT_ONE;
                    end
                end
                default: begin
                    ena_r   <= {NUM_LATCH{1'b0}};
                    busy_r  <= 1'b0;
                    cnt_r   <= CNT_ZERO;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign req_ready = ready_s;
    assign d         = d_r;
    assign ena       = ena_r;
    assign busy      = busy_r;
    assign done      = done_r;
    assign err       = err_r;

endmodule

// File: tb/tb_latch_write_sequencer.sv
// Bench for latch_write_sequencer: three instances (default timing, a 3-latch
// bank for out-of-range addresses, and a 3/1/2 timing sweep) each drive a bank
// of behavioural latches. A timeline model predicts every output from the
// number of cycles elapsed since the last acceptance.
module tb_latch_write_sequencer;

    localparam int ND = 3;
    localparam int S_P [ND] = '{1, 1, 3};
    localparam int E_P [ND] = '{2, 2, 1};
    localparam int H_P [ND] = '{1, 1, 2};
    localparam int N_P [ND] = '{4, 3, 4};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst [ND];
    logic       vld [ND];
    logic [1:0] adr [ND];
    logic [7:0] dat [ND];
    logic       rdy [ND];
    logic       bsy [ND];
    logic       dne [ND];
    logic       erf [ND];
    logic [7:0] dq  [ND];
    logic [3:0] ena0;
    logic [2:0] ena1;
    logic [3:0] ena2;
    logic [3:0] ena_w [ND];

    assign ena_w[0] = ena0;
    assign ena_w[1] = {1'b0, ena1};
    assign ena_w[2] = ena2;

    latch_write_sequencer #(.WIDTH(8), .NUM_LATCH(4), .ADDR_W(2),
        .SETUP_CYCLES(1), .ENA_CYCLES(2), .HOLD_CYCLES(1)) dut0 (
        .clk(clk), .reset(rst[0]), .req_valid(vld[0]), .req_ready(rdy[0]),
        .req_addr(adr[0]), .req_data(dat[0]), .d(dq[0]), .ena(ena0),
        .busy(bsy[0]), .done(dne[0]), .err(erf[0]));

    latch_write_sequencer #(.WIDTH(8), .NUM_LATCH(3), .ADDR_W(2),
        .SETUP_CYCLES(1), .ENA_CYCLES(2), .HOLD_CYCLES(1)) dut1 (
        .clk(clk), .reset(rst[1]), .req_valid(vld[1]), .req_ready(rdy[1]),
        .req_addr(adr[1]), .req_data(dat[1]), .d(dq[1]), .ena(ena1),
        .busy(bsy[1]), .done(dne[1]), .err(erf[1]));

    latch_write_sequencer #(.WIDTH(8), .NUM_LATCH(4), .ADDR_W(2),
        .SETUP_CYCLES(3), .ENA_CYCLES(1), .HOLD_CYCLES(2)) dut2 (
        .clk(clk), .reset(rst[2]), .req_valid(vld[2]), .req_ready(rdy[2]),
        .req_addr(adr[2]), .req_data(dat[2]), .d(dq[2]), .ena(ena2),
        .busy(bsy[2]), .done(dne[2]), .err(erf[2]));

    logic [7:0] q0 [4];
    logic [7:0] q1 [3];
    logic [7:0] q2 [4];

    // Behavioural transparent latches for bank 0
    always_latch begin
        for (int j = 0; j < 4; j++) if (ena0[j]) q0[j] <= dq[0];
    end
    // Behavioural transparent latches for bank 1
    always_latch begin
        for (int j = 0; j < 3; j++) if (ena1[j]) q1[j] <= dq[1];
    end
    // Behavioural transparent latches for bank 2
    always_latch begin
        for (int j = 0; j < 4; j++) if (ena2[j]) q2[j] <= dq[2];
    end

    // Reference model state
    int         age      [ND];   // cycles since the last acceptance edge, 0 = idle
    logic [1:0] m_addr   [ND];
    logic [7:0] d_exp    [ND];
    logic [7:0] mem      [ND][4];
    bit         known    [ND][4];
    bit         last_acc [ND];
    logic [7:0] prev_d   [ND];
    int         cyc;
    int         n_cmp = 0;
    int         n_err = 0;

    function automatic int tot(input int i);
        return S_P[i] + E_P[i] + H_P[i];
    endfunction

    function automatic logic [7:0] qget(input int i, input int j);
        case (i)
            0:       return q0[j];
            1:       return (j < 3) ? q1[j] : 8'h00;
            default: return q2[j];
        endcase
    endfunction

    function automatic logic [3:0] exp_ena(input int i);
        if (age[i] >= S_P[i] + 1 && age[i] <= S_P[i] + E_P[i] && int'(m_addr[i]) < N_P[i])
            return 4'b0001 << m_addr[i];
        return 4'h0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_dut(input int i);
        bit idle_or_done;
        bit in_done;
        idle_or_done = (age[i] == 0) || (age[i] == tot(i) + 1);
        in_done      = (age[i] == tot(i) + 1);
        chk($sformatf("dut%0d.req_ready", i), 32'(rdy[i]), 32'(idle_or_done && !rst[i]));
        chk($sformatf("dut%0d.busy", i), 32'(bsy[i]), 32'(age[i] >= 1 && age[i] <= tot(i)));
        chk($sformatf("dut%0d.done", i), 32'(dne[i]), 32'(in_done));
        chk($sformatf("dut%0d.err", i), 32'(erf[i]), 32'(in_done && int'(m_addr[i]) >= N_P[i]));
        chk($sformatf("dut%0d.d", i), 32'(dq[i]), 32'(d_exp[i]));
        chk($sformatf("dut%0d.ena", i), 32'(ena_w[i]), 32'(exp_ena(i)));
        if (dq[i] !== prev_d[i])
            chk($sformatf("dut%0d.ena_on_d_change", i), 32'(ena_w[i]), 32'h0);
        for (int j = 0; j < N_P[i]; j++)
            if (known[i][j])
                chk($sformatf("dut%0d.latch%0d_q", i, j), 32'(qget(i, j)), 32'(mem[i][j]));
    endtask

    // One clock: predict acceptances, advance the model at the edge, compare mid-cycle.
    task automatic tick();
        bit acc [ND];
        for (int i = 0; i < ND; i++) begin
            acc[i]    = vld[i] && !rst[i] && (age[i] == 0 || age[i] == tot(i) + 1);
            prev_d[i] = dq[i];
        end
        @(posedge clk);
        cyc++;
        for (int i = 0; i < ND; i++) begin
            last_acc[i] = acc[i];
            if (rst[i]) begin
                age[i]   = 0;
                d_exp[i] = 8'h00;
            end else if (acc[i]) begin
                age[i]    = 1;
                m_addr[i] = adr[i];
                d_exp[i]  = dat[i];
            end else if (age[i] == 0 || age[i] == tot(i) + 1) begin
                age[i] = 0;
            end else begin
                age[i]++;
            end
            if (exp_ena(i) != 4'h0) begin
                mem[i][m_addr[i]]   = d_exp[i];
                known[i][m_addr[i]] = 1'b1;
            end
        end
        @(negedge clk);
        for (int i = 0; i < ND; i++) check_dut(i);
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    // Present a request (valid stays high) and wait, bounded, for its acceptance.
    task automatic send(input int i, input logic [1:0] a, input logic [7:0] v);
        int guard;
        guard  = 0;
        vld[i] = 1'b1;
        adr[i] = a;
        dat[i] = v;
        do begin
            tick();
            guard++;
        end while (!last_acc[i] && guard < 40);
        chk($sformatf("dut%0d.accepted", i), 32'(last_acc[i]), 32'h1);
    endtask

    initial begin
        int         c1;
        int         c2;
        int         n_acc;
        int         ena_cnt;
        int         ena_first;
        int         done_at;
        logic [7:0] snap [3];

        cyc = 0;
        for (int i = 0; i < ND; i++) begin
            rst[i] = 1'b1; vld[i] = 1'b0; adr[i] = 2'd0; dat[i] = 8'h00;
            age[i] = 0; m_addr[i] = 2'd0; d_exp[i] = 8'h00; last_acc[i] = 1'b0;
            for (int j = 0; j < 4; j++) begin
                mem[i][j] = 8'h00; known[i][j] = 1'b0;
            end
        end
        run(2);
        for (int i = 0; i < ND; i++) rst[i] = 1'b0;
        run(1);

        // Give every latch a known random value.
        for (int i = 0; i < ND; i++) begin
            for (int j = 0; j < N_P[i]; j++) send(i, 2'(j), 8'($urandom));
            vld[i] = 1'b0;
        end
        run(10);

        // Single write, default timing.
        send(0, 2'd2, 8'hA5);
        vld[0] = 1'b0;
        run(6);
        chk("single_latch2", 32'(q0[2]), 32'hA5);

        // Back-to-back writes accepted in the done cycle.
        send(0, 2'd0, 8'h11);
        c1 = cyc;
        send(0, 2'd3, 8'h3C);
        c2 = cyc;
        vld[0] = 1'b0;
        chk("b2b_spacing", 32'(c2 - c1), 32'd5);
        run(6);
        chk("b2b_latch0", 32'(q0[0]), 32'h11);
        chk("b2b_latch3", 32'(q0[3]), 32'h3C);

        // Out-of-range address on the 3-latch bank.
        for (int j = 0; j < 3; j++) snap[j] = q1[j];
        send(1, 2'd3, 8'hFF);
        vld[1] = 1'b0;
        run(6);
        for (int j = 0; j < 3; j++) chk($sformatf("oor_latch%0d", j), 32'(q1[j]), 32'(snap[j]));

        // Reset while the enable window is open.
        send(0, 2'd1, 8'($urandom));
        vld[0] = 1'b0;
        tick();
        chk("pre_rst_ena", 32'(ena0), 32'h2);
        rst[0] = 1'b1;
        tick();
        chk("rst_ena", 32'(ena0), 32'h0);
        chk("rst_d", 32'(dq[0]), 32'h0);
        chk("rst_busy", 32'(bsy[0]), 32'h0);
        rst[0] = 1'b0;
        tick();
        chk("rst_ready", 32'(rdy[0]), 32'h1);
        run(6);

        // Valid held high with changing data and addresses.
        n_acc  = 0;
        vld[0] = 1'b1;
        repeat (20) begin
            adr[0] = 2'($urandom_range(3, 0));
            dat[0] = 8'($urandom);
            tick();
            if (last_acc[0]) n_acc++;
        end
        vld[0] = 1'b0;
        chk("held_accepts", 32'(n_acc), 32'd4);
        run(6);

        // Timing sweep instance: setup 3, enable 1, hold 2.
        ena_cnt   = 0;
        ena_first = 0;
        done_at   = 0;
        send(2, 2'($urandom_range(3, 0)), 8'($urandom));
        c1     = cyc;
        vld[2] = 1'b0;
        repeat (9) begin
            tick();
            if (ena2 != 4'h0) begin
                ena_cnt++;
                if (ena_first == 0) ena_first = cyc - c1 + 1;
            end
            if (dne[2]) done_at = cyc - c1 + 1;
        end
        chk("sweep_ena_cycles", 32'(ena_cnt), 32'd1);
        chk("sweep_ena_first", 32'(ena_first), 32'd4);
        chk("sweep_done_cycle", 32'(done_at), 32'd7);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
